// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller: gate state encoding and
// default timing constants used by both lane FSMs.
package parking_pkg;

    localparam logic [1:0] GATE_IDLE  = 2'd0;
    localparam logic [1:0] GATE_CHECK = 2'd1;
    localparam logic [1:0] GATE_OPEN  = 2'd2;
    localparam logic [1:0] GATE_CLOSE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = GATE_IDLE,
        ST_CHECK = GATE_CHECK,
        ST_OPEN  = GATE_OPEN,
        ST_CLOSE = GATE_CLOSE
    } gate_state_e;

    localparam int unsigned DEF_OPEN_TIMEOUT = 500;
    localparam int unsigned DEF_CLOSE_CYCLES = 20;
    localparam int unsigned DEF_TW           = 16;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Lane sensor, vacancy and command/pulse signals between the gate controller
// and its surroundings (sensors, barriers, occupancy counter).
interface parking_gate_ctrl_if;

    logic entry_req;
    logic entry_is_uni;
    logic entry_passed;
    logic exit_req;
    logic exit_is_uni;
    logic exit_passed;
    logic uni_is_vacated_space;
    logic is_vacated_space;

    logic car_entered;
    logic is_uni_car_enterd;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_barrier_up;
    logic exit_barrier_up;
    logic entry_denied;
    logic entry_timeout;
    logic exit_timeout;

    modport master (
        output entry_req, entry_is_uni, entry_passed,
        output exit_req, exit_is_uni, exit_passed,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited,
        input  entry_barrier_up, exit_barrier_up,
        input  entry_denied, entry_timeout, exit_timeout
    );

    modport slave (
        input  entry_req, entry_is_uni, entry_passed,
        input  exit_req, exit_is_uni, exit_passed,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited,
        output entry_barrier_up, exit_barrier_up,
        output entry_denied, entry_timeout, exit_timeout
    );

endinterface

// File: rtl/parking_gate_fsm.sv
// One lane of the parking gate: request edge detect, car type latch, open/close
// timer and the IDLE/CHECK/OPEN/CLOSE barrier sequencer with registered outputs.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter bit          ALWAYS_ADMIT = 1'b0,
    parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int unsigned TW           = DEF_TW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic req_is_uni,
    input  logic passed,
    input  logic vacant,
    output logic latched_is_uni,
    output logic barrier_up,
    output logic pulse,
    output logic pulse_is_uni,
    output logic denied,
    output logic timeout
);

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = (CLOSE_CYCLES == 0) ? '0 : TW'(CLOSE_CYCLES - 1);

    gate_state_e     state_q, state_d;
    logic            req_q;
    logic            type_q, type_d;
    logic [TW-1:0]   timer_q, timer_d, timer_inc;
    logic            barrier_q, barrier_d;
    logic            pulse_q, pulse_d;
    logic            pulse_uni_q, pulse_uni_d;
    logic            denied_q, denied_d;
    logic            timeout_q, timeout_d;

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        timer_d     = timer_q;
        barrier_d   = 1'b0;
        pulse_d     = 1'b0;
        pulse_uni_d = 1'b0;
        denied_d    = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (req && !req_q) begin
                    type_d  = req_is_uni;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (ALWAYS_ADMIT || vacant) begin
                    state_d   = ST_OPEN;
                    barrier_d = 1'b1;
                end else begin
                    denied_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_OPEN: begin
                // A pass on the final timeout cycle still counts as a car.
                if (passed) begin
                    pulse_d     = 1'b1;
                    pulse_uni_d = type_q;
                    timer_d     = '0;
                    state_d     = ST_CLOSE;
                end else if (timer_q >= OPEN_LAST) begin
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_CLOSE;
                end else begin
                    barrier_d = 1'b1;
                    timer_d   = timer_inc;
                end
            end
            ST_CLOSE: begin
                if (timer_q >= CLOSE_LAST) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            // A request held through reset must not look like a fresh arrival.
            req_q       <= 1'b1;
            type_q      <= 1'b0;
            timer_q     <= '0;
            barrier_q   <= 1'b0;
            pulse_q     <= 1'b0;
            pulse_uni_q <= 1'b0;
            denied_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req;
            type_q      <= type_d;
            timer_q     <= timer_d;
            barrier_q   <= barrier_d;
            pulse_q     <= pulse_d;
            pulse_uni_q <= pulse_uni_d;
            denied_q    <= denied_d;
            timeout_q   <= timeout_d;
        end
    end

    assign latched_is_uni = type_q;
    assign barrier_up     = barrier_q;
    assign pulse          = pulse_q;
    assign pulse_is_uni   = pulse_uni_q;
    assign denied         = denied_q;
    assign timeout        = timeout_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller top: entry and exit lane sequencers, with the entry
// vacancy check selected by the latched car type.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int unsigned TW           = DEF_TW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parking_gate_ctrl_if.slave   bus
);

    logic entry_type, entry_vacant;
    logic entry_bar, entry_pulse, entry_pulse_uni, entry_den, entry_to;
    logic exit_type, exit_bar, exit_pulse, exit_pulse_uni, exit_den, exit_to;
    logic unused_exit;

    assign entry_vacant = entry_type ? bus.uni_is_vacated_space : bus.is_vacated_space;

    parking_gate_fsm #(
        .ALWAYS_ADMIT (1'b0),
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES),
        .TW           (TW)
    ) u_entry (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (bus.entry_req),
        .req_is_uni     (bus.entry_is_uni),
        .passed         (bus.entry_passed),
        .vacant         (entry_vacant),
        .latched_is_uni (entry_type),
        .barrier_up     (entry_bar),
        .pulse          (entry_pulse),
        .pulse_is_uni   (entry_pulse_uni),
        .denied         (entry_den),
        .timeout        (entry_to)
    );

    parking_gate_fsm #(
        .ALWAYS_ADMIT (1'b1),
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES),
        .TW           (TW)
    ) u_exit (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (bus.exit_req),
        .req_is_uni     (bus.exit_is_uni),
        .passed         (bus.exit_passed),
        .vacant         (1'b1),
        .latched_is_uni (exit_type),
        .barrier_up     (exit_bar),
        .pulse          (exit_pulse),
        .pulse_is_uni   (exit_pulse_uni),
        .denied         (exit_den),
        .timeout        (exit_to)
    );

    // The exit lane never refuses and needs no vacancy type.
    assign unused_exit = exit_den ^ exit_type;

    assign bus.entry_barrier_up  = entry_bar;
    assign bus.car_entered       = entry_pulse;
    assign bus.is_uni_car_enterd = entry_pulse_uni;
    assign bus.entry_denied      = entry_den;
    assign bus.entry_timeout     = entry_to;
    assign bus.exit_barrier_up   = exit_bar;
    assign bus.car_exited        = exit_pulse;
    assign bus.is_uni_car_exited = exit_pulse_uni;
    assign bus.exit_timeout      = exit_to;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus randomized
// lane transactions compared against a window-based expectation model.
module tb_parking_gate_ctrl;

    localparam int OT = 500;
    localparam int CC = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cnt_entered = 0;
    int   cnt_exited = 0;
    int   exp_entered = 0;
    int   exp_exited = 0;

    parking_gate_ctrl_if bus ();

    parking_gate_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_entry_barrier_up"}, bus.entry_barrier_up, 1'b0);
        chk({tag, "_exit_barrier_up"},  bus.exit_barrier_up, 1'b0);
        chk({tag, "_car_entered"},      bus.car_entered, 1'b0);
        chk({tag, "_is_uni_enterd"},    bus.is_uni_car_enterd, 1'b0);
        chk({tag, "_car_exited"},       bus.car_exited, 1'b0);
        chk({tag, "_is_uni_exited"},    bus.is_uni_car_exited, 1'b0);
        chk({tag, "_entry_denied"},     bus.entry_denied, 1'b0);
        chk({tag, "_entry_timeout"},    bus.entry_timeout, 1'b0);
        chk({tag, "_exit_timeout"},     bus.exit_timeout, 1'b0);
    endtask

    task automatic drive_idle();
        bus.entry_req = 1'b0; bus.entry_is_uni = 1'b0; bus.entry_passed = 1'b0;
        bus.exit_req  = 1'b0; bus.exit_is_uni  = 1'b0; bus.exit_passed  = 1'b0;
        bus.uni_is_vacated_space = 1'b0; bus.is_vacated_space = 1'b0;
    endtask

    // One transaction per lane starting together. The expected outputs after
    // edge c are windows derived from when the request, the vacancy decision
    // and the pass happen: barrier over cycles [2, 2+len), pulse/timeout at
    // 2+len, refusal at 2, lane idle again CC cycles after the pulse point.
    task automatic run_pair(input bit e_act, input bit e_uni, input bit e_pass, input int e_j,
                            input bit x_act, input bit x_uni, input bit x_pass, input int x_j,
                            input bit uni_vac, input bit ord_vac, input string tag);
        bit e_adm;
        int e_len, e_end, x_len, x_end, kmax, e_hold, x_hold;
        e_adm  = e_act && (e_uni ? uni_vac : ord_vac);
        e_len  = e_pass ? e_j + 1 : OT;
        x_len  = x_pass ? x_j + 1 : OT;
        e_end  = !e_act ? 0 : (e_adm ? 2 + e_len + CC : 2);
        x_end  = x_act ? 2 + x_len + CC : 0;
        e_hold = $urandom_range(1, 2);
        x_hold = $urandom_range(1, 2);
        kmax   = (e_end > x_end) ? e_end : x_end;
        if (e_adm && e_pass) exp_entered++;
        if (x_act && x_pass) exp_exited++;
        for (int k = 0; k <= kmax; k++) begin
            int  c;
            bit  e_close, x_close;
            c       = k + 1;
            e_close = e_adm && (k >= 2 + e_len) && (k < 2 + e_len + CC);
            x_close = x_act && (k >= 2 + x_len) && (k < 2 + x_len + CC);
            bus.entry_req    = (e_act && c <= e_hold) || (e_close && 1'($urandom_range(0, 1)));
            bus.exit_req     = (x_act && c <= x_hold) || (x_close && 1'($urandom_range(0, 1)));
            bus.entry_is_uni = (c == 1) ? e_uni : 1'($urandom_range(0, 1));
            bus.exit_is_uni  = (c == 1) ? x_uni : 1'($urandom_range(0, 1));
            bus.uni_is_vacated_space = (c == 2) ? uni_vac : 1'($urandom_range(0, 1));
            bus.is_vacated_space     = (c == 2) ? ord_vac : 1'($urandom_range(0, 1));
            bus.entry_passed = (e_adm && e_pass && c == 3 + e_j) || (e_close && 1'($urandom_range(0, 1)));
            bus.exit_passed  = (x_act && x_pass && c == 3 + x_j) || (x_close && 1'($urandom_range(0, 1)));
            tick();
            chk({tag, "_entry_barrier_up"}, bus.entry_barrier_up, e_adm && c >= 2 && c < 2 + e_len);
            chk({tag, "_car_entered"}, bus.car_entered, e_adm && e_pass && c == 2 + e_len);
            chk({tag, "_is_uni_enterd"}, bus.is_uni_car_enterd, e_adm && e_pass && e_uni && c == 2 + e_len);
            chk({tag, "_entry_timeout"}, bus.entry_timeout, e_adm && !e_pass && c == 2 + e_len);
            chk({tag, "_entry_denied"}, bus.entry_denied, e_act && !e_adm && c == 2);
            chk({tag, "_exit_barrier_up"}, bus.exit_barrier_up, x_act && c >= 2 && c < 2 + x_len);
            chk({tag, "_car_exited"}, bus.car_exited, x_act && x_pass && c == 2 + x_len);
            chk({tag, "_is_uni_exited"}, bus.is_uni_car_exited, x_act && x_pass && x_uni && c == 2 + x_len);
            chk({tag, "_exit_timeout"}, bus.exit_timeout, x_act && !x_pass && c == 2 + x_len);
            cnt_entered += int'(bus.car_entered);
            cnt_exited  += int'(bus.car_exited);
        end
        drive_idle();
    endtask

    initial begin
        int base_e, base_x;
        bit t_e, t_x;
        int jj;

        // Reset with requests held: nothing may open, even after release.
        drive_idle();
        bus.entry_req = 1'b1; bus.exit_req = 1'b1;
        bus.is_vacated_space = 1'b1; bus.uni_is_vacated_space = 1'b1;
        rst_n = 1'b0;
        repeat (3) begin tick(); chk_all_zero("reset"); end
        rst_n = 1'b1;
        repeat (5) begin tick(); chk_all_zero("held_req"); end
        drive_idle();
        tick(); chk_all_zero("req_drop");
        $display("reset: held requests ignored");

        // University entry with only uni vacancy.
        run_pair(1, 1, 1, 3, 0, 0, 0, 0, 1, 0, "uni_entry");
        chk_int("uni_entry_count", cnt_entered, exp_entered);
        $display("uni entry: entered=%0d", cnt_entered);

        // Ordinary entry refused.
        run_pair(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "ord_denied");
        chk_int("ord_denied_count", cnt_entered, exp_entered);
        $display("ordinary entry denied: entered=%0d", cnt_entered);

        // Both lanes time out; then pass on the very last open cycle.
        run_pair(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, "timeout");
        $display("timeout: both lanes");
        run_pair(1, 1, 1, OT - 1, 1, 0, 1, OT - 1, 1, 1, "last_cycle_pass");
        chk_int("last_pass_entered", cnt_entered, exp_entered);
        chk_int("last_pass_exited", cnt_exited, exp_exited);
        $display("pass on last open cycle: entered=%0d exited=%0d", cnt_entered, cnt_exited);

        // 50 lock-step entry/exit cars.
        base_e = cnt_entered;
        base_x = cnt_exited;
        for (int i = 0; i < 50; i++) begin
            t_e = 1'($urandom_range(0, 1));
            t_x = 1'($urandom_range(0, 1));
            jj  = $urandom_range(0, 5);
            run_pair(1, t_e, 1, jj, 1, t_x, 1, jj, 1, 1, "lockstep");
            $display("lockstep %0d: entry_uni=%0b exit_uni=%0b pass_at=%0d", i, t_e, t_x, jj);
        end
        chk_int("lockstep_entered", cnt_entered - base_e, 50);
        chk_int("lockstep_exited", cnt_exited - base_x, 50);

        // Reset while both barriers are open, with passes pending.
        bus.entry_req = 1'b1; bus.exit_req = 1'b1;
        bus.is_vacated_space = 1'b1; bus.uni_is_vacated_space = 1'b1;
        tick();
        bus.entry_req = 1'b0; bus.exit_req = 1'b0;
        tick(); tick();
        chk("rst_open_entry_up", bus.entry_barrier_up, 1'b1);
        chk("rst_open_exit_up", bus.exit_barrier_up, 1'b1);
        bus.entry_passed = 1'b1; bus.exit_passed = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_open_async");
        repeat (2) begin tick(); chk_all_zero("rst_open_hold"); end
        drive_idle();
        rst_n = 1'b1;
        repeat (3) begin tick(); chk_all_zero("rst_open_release"); end
        $display("reset during open: barriers dropped, no pulse");

        // Randomized lane transactions.
        for (int i = 0; i < 30; i++) begin
            bit ea, eu, ep, xa, xu, xp, uv, ov;
            int ej, xj;
            ea = ($urandom_range(0, 9) != 0);
            xa = ($urandom_range(0, 9) != 0);
            eu = 1'($urandom_range(0, 1));
            xu = 1'($urandom_range(0, 1));
            ep = ($urandom_range(0, 14) != 0);
            xp = ($urandom_range(0, 14) != 0);
            ej = $urandom_range(0, 8);
            xj = $urandom_range(0, 8);
            uv = 1'($urandom_range(0, 1));
            ov = 1'($urandom_range(0, 1));
            run_pair(ea, eu, ep, ej, xa, xu, xp, xj, uv, ov, "random");
            $display("random %0d: entry act=%0b uni=%0b pass=%0b@%0d vac=%0b/%0b exit act=%0b uni=%0b pass=%0b@%0d",
                     i, ea, eu, ep, ej, uv, ov, xa, xu, xp, xj);
        end
        chk_int("total_entered", cnt_entered, exp_entered);
        chk_int("total_exited", cnt_exited, exp_exited);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
